ram_burst_reader: RTL and testbench

Sequential read engine for the 16x4 RAM's combinational read port. On a start command it walks a run of consecutive RAM addresses, registers each word, and streams the words downstream over a valid/ready handshake with a last-beat marker. It sits directly downstream of the RAM: it drives the RAM read address and consumes the RAM read data. It never touches the write port.

---
 rtl/ram_burst_if.sv | 28 ++
 rtl/ram_burst_reader.sv | 85 ++++++++
 tb/tb_ram_burst_reader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_if.sv
// Command, RAM read-port and beat-stream signals of the burst reader.
// The master modport is the engine side; slave is the surrounding environment.
interface ram_burst_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] length;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, length, rd_data, out_ready,
    output rd_addr, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    output start, base_addr, length, rd_data, out_ready,
    input  rd_addr, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Walks consecutive RAM addresses through the combinational read port and
// streams each registered word over valid/ready, marking the final beat.
module ram_burst_reader #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  ram_burst_if.master    bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] len_q;
  logic [IDX_W-1:0]  idx_next;
  logic              slot_free;
  logic              last_beat;
  logic              unused_base_hi;

  // Output slot can take a new word when empty or when its beat leaves this edge.
  assign slot_free      = !bus.out_valid || bus.out_ready;
  assign last_beat      = (count == len_q - ADDR_W'(1));
  assign idx_next       = bus.rd_addr[IDX_W-1:0] + IDX_W'(1);
  assign unused_base_hi = ^bus.base_addr[ADDR_W-1:IDX_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      len_q         <= '0;
      bus.rd_addr   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (bus.length != '0) begin
              len_q       <= bus.length;
              bus.rd_addr <= ADDR_W'(bus.base_addr[IDX_W-1:0]);
              count       <= '0;
              state       <= RUN;
            end else begin
              bus.done <= 1'b1;
              state    <= FIN;
            end
          end
        end
        RUN: begin
          if (slot_free) begin
            bus.out_data  <= bus.rd_data;
            bus.out_valid <= 1'b1;
            bus.out_last  <= last_beat;
            bus.rd_addr   <= ADDR_W'(idx_next);
            count         <= count + ADDR_W'(1);
            if (last_beat) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.done      <= 1'b1;
            state         <= FIN;
          end
        end
        FIN: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a 16x4 RAM model on the read port.
module tb_ram_burst_reader;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_burst_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_burst_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM model: synchronous write, combinational read
  logic [DATA_W-1:0] mem [DEPTH];
  logic              we;
  logic [3:0]        waddr;
  logic [DATA_W-1:0] wdata;
  always @(posedge clk) if (we) mem[waddr] <= wdata;
  assign bus.rd_data = mem[bus.rd_addr[3:0]];

  // Beat / pulse monitor, sampled mid-cycle
  logic [DATA_W-1:0] beat_d [$];
  logic              beat_l [$];
  int done_cnt  = 0;
  int valid_cnt = 0;
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      beat_d.push_back(bus.out_data);
      beat_l.push_back(bus.out_last);
    end
    if (bus.done) done_cnt++;
    if (bus.out_valid) valid_cnt++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (cyc >= 200) check("done_timeout", 32'(bus.done), 1);
  endtask

  task automatic check_beats(input string tag, input int bi, input int n, input int e [8]);
    int got_n;
    got_n = beat_d.size() - bi;
    check({tag, "_count"}, 32'(got_n), 32'(n));
    for (int k = 0; k < n && k < got_n; k++) begin
      check({tag, "_data"}, 32'(beat_d[bi+k]), 32'(e[k]));
      check({tag, "_last"}, 32'(beat_l[bi+k]), (k == n - 1) ? 1 : 0);
    end
  endtask

  task automatic issue(input int base, input int len);
    bus.start     = 1'b1;
    bus.base_addr = ADDR_W'(base);
    bus.length    = ADDR_W'(len);
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bi, dc, vc, cyc;
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.out_ready = 1'b1;
    we = 1'b0; waddr = '0; wdata = '0;

    // preload mem[i] = i while the engine is held in reset
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; waddr = 4'(i); wdata = DATA_W'(i);
      tick();
    end
    we = 1'b0;
    check("rst_rd_addr", 32'(bus.rd_addr), 0);
    check("rst_valid",   32'(bus.out_valid), 0);
    check("rst_data",    32'(bus.out_data), 0);
    check("rst_last",    32'(bus.out_last), 0);
    check("rst_busy",    32'(bus.busy), 0);
    check("rst_done",    32'(bus.done), 0);
    rst_n = 1'b1;
    tick();

    // base 3, length 4, no stalls
    bi = beat_d.size(); dc = done_cnt;
    issue(3, 4);
    check("t1_busy",    32'(bus.busy), 1);
    check("t1_rd_addr", 32'(bus.rd_addr), 3);
    check("t1_valid0",  32'(bus.out_valid), 0);
    wait_done(cyc);
    check("t1_done_lat", 32'(cyc), 5);
    tick();
    check("t1_busy_end", 32'(bus.busy), 0);
    check("t1_done_end", 32'(bus.done), 0);
    check_beats("t1", bi, 4, '{3, 4, 5, 6, 0, 0, 0, 0});
    check("t1_done_cnt", 32'(done_cnt - dc), 1);

    // base 14 wraps to 0
    bi = beat_d.size();
    issue(14, 4);
    check("t2_addr0", 32'(bus.rd_addr), 14);
    tick();
    check("t2_addr1", 32'(bus.rd_addr), 15);
    check("t2_data0", 32'(bus.out_data), 14);
    tick();
    check("t2_addr2", 32'(bus.rd_addr), 0);
    check("t2_msb2",  32'(bus.rd_addr[4]), 0);
    check("t2_data1", 32'(bus.out_data), 15);
    tick();
    check("t2_addr3", 32'(bus.rd_addr), 1);
    check("t2_data2", 32'(bus.out_data), 0);
    tick();
    check("t2_data3", 32'(bus.out_data), 1);
    check("t2_last3", 32'(bus.out_last), 1);
    wait_done(cyc);
    tick();
    check_beats("t2", bi, 4, '{14, 15, 0, 1, 0, 0, 0, 0});

    // backpressure after the second beat
    bi = beat_d.size();
    issue(0, 5);
    tick();
    tick();
    check("t3_data_e2", 32'(bus.out_data), 1);
    check("t3_addr_e2", 32'(bus.rd_addr), 2);
    bus.out_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tick();
      check("t3_hold_valid", 32'(bus.out_valid), 1);
      check("t3_hold_data",  32'(bus.out_data), 1);
      check("t3_hold_addr",  32'(bus.rd_addr), 2);
    end
    bus.out_ready = 1'b1;
    wait_done(cyc);
    tick();
    check_beats("t3", bi, 5, '{0, 1, 2, 3, 4, 0, 0, 0});

    // empty burst
    vc = valid_cnt; dc = done_cnt;
    issue(0, 0);
    check("t4_done",  32'(bus.done), 1);
    check("t4_busy",  32'(bus.busy), 1);
    check("t4_valid", 32'(bus.out_valid), 0);
    tick();
    check("t4_done_end", 32'(bus.done), 0);
    check("t4_busy_end", 32'(bus.busy), 0);
    check("t4_no_valid", 32'(valid_cnt - vc), 0);
    check("t4_done_cnt", 32'(done_cnt - dc), 1);

    // second start while busy is ignored
    bi = beat_d.size(); dc = done_cnt;
    issue(2, 3);
    tick();
    issue(9, 7);
    wait_done(cyc);
    tick();
    check_beats("t4b", bi, 3, '{2, 3, 4, 0, 0, 0, 0, 0});
    check("t4b_done_cnt", 32'(done_cnt - dc), 1);

    // reset mid-burst
    dc = done_cnt;
    issue(5, 6);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_rd_addr", 32'(bus.rd_addr), 0);
    check("t5_valid",   32'(bus.out_valid), 0);
    check("t5_data",    32'(bus.out_data), 0);
    check("t5_last",    32'(bus.out_last), 0);
    check("t5_busy",    32'(bus.busy), 0);
    check("t5_done",    32'(bus.done), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t5_no_done", 32'(done_cnt - dc), 0);
    bi = beat_d.size();
    issue(9, 2);
    wait_done(cyc);
    tick();
    check_beats("t5b", bi, 2, '{9, 10, 0, 0, 0, 0, 0, 0});

    // write to address 7 on the edge that captures it: old word wins
    bi = beat_d.size();
    issue(6, 3);
    tick();
    we = 1'b1; waddr = 4'd7; wdata = 4'hA;
    tick();
    we = 1'b0;
    check("t6_capture", 32'(bus.out_data), 7);
    wait_done(cyc);
    tick();
    check_beats("t6", bi, 3, '{6, 7, 8, 0, 0, 0, 0, 0});
    bi = beat_d.size();
    issue(7, 1);
    wait_done(cyc);
    check("t6b_done_lat", 32'(cyc), 2);
    tick();
    check_beats("t6b", bi, 1, '{10, 0, 0, 0, 0, 0, 0, 0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
